// File: rtl/post_fft_bram_reader.sv
// Streams one frame from post-FFT BRAM port B as an AXI4-Stream master.
// BRAM read latency is absorbed by a small FIFO sized to keep one beat per cycle.
module post_fft_bram_reader #(
    parameter int          NUM_WORDS    = 2048,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP    = 32'd4,
    parameter int          READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] addrb,
    output logic        enb,
    output logic [3:0]  web,
    input  logic [31:0] doutb,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [1:0]  dbg_state
);

    localparam int FIFO_DEPTH = READ_LATENCY + 2;
    localparam int CW         = $clog2(NUM_WORDS + 1);
    localparam int FCW        = $clog2(FIFO_DEPTH + 1);
    localparam int PW         = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0]  WORDS    = CW'(NUM_WORDS);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NUM_WORDS - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [PW-1:0]  PTR_MAX  = PW'(FIFO_DEPTH - 1);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
    localparam logic [FCW-1:0] DEPTH_C  = FCW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]           issued;
    logic [CW-1:0]           out_cnt;
    logic [31:0]             addr_q;
    logic [READ_LATENCY-1:0] vld;
    logic [FCW-1:0]          inflight;
    logic [FCW-1:0]          fifo_count;
    logic [31:0]             fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;

    logic issue_ok;
    logic start_acc;
    logic push;
    logic pop;
    logic fire;

    // Stream handshake: a beat moves on any edge where tvalid && tready; while
    // tvalid is high and tready low, tdata/tlast hold because the FIFO head
    // only moves on a pop.
    assign fire      = m_axis_tvalid && m_axis_tready;
    assign pop       = fire;
    assign push      = vld[READ_LATENCY-1];
    assign start_acc = (state == IDLE) && start;

    // Reads are only launched when a FIFO slot is guaranteed for their data.
    assign issue_ok = (state == READ) && (issued != WORDS) &&
                      ((fifo_count + inflight) < DEPTH_C);

    assign m_axis_tvalid = (fifo_count != '0);
    assign m_axis_tdata  = fifo_mem[rd_ptr];
    assign m_axis_tlast  = m_axis_tvalid && (out_cnt == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (issue_ok && (issued == LAST_IDX)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fire && m_axis_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        enb       = issue_ok;
        addrb     = issue_ok ? addr_q : 32'h0000_0000;
        web       = 4'b0000;
        busy      = (state != IDLE);
        dbg_state = state;
    end

    // Issue and output counters; the byte address is tracked incrementally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            issued  <= '0;
            out_cnt <= '0;
            addr_q  <= BASE_ADDR;
        end else if (start_acc) begin
            issued  <= '0;
            out_cnt <= '0;
            addr_q  <= BASE_ADDR;
        end else begin
            if (issue_ok) begin
                issued <= issued + CNT_ONE;
                addr_q <= addr_q + ADDR_STEP;
            end
            if (fire) begin
                out_cnt <= out_cnt + CNT_ONE;
            end
        end
    end

    // In-flight tracker: vld[READ_LATENCY-1] marks the edge doutb holds read data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld      <= '0;
            inflight <= '0;
        end else begin
            vld[0] <= issue_ok;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end
            inflight <= inflight + FCW'(issue_ok) - FCW'(push);
        end
    end

    // Data FIFO; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= doutb;
                wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PTR_ONE;
            end
            fifo_count <= fifo_count + FCW'(push) - FCW'(pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done <= 1'b0;
        end else begin
            done <= fire && m_axis_tlast;
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(push && !pop && (fifo_count == DEPTH_C)));

endmodule

// File: tb/tb_post_fft_bram_reader.sv
// Bench for post_fft_bram_reader: full-size frame instance plus a 4-word instance.
module tb_post_fft_bram_reader;

    localparam int N = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    logic        start_a, busy_a, done_a, enb_a, tvalid_a, tready_a, tlast_a;
    logic [31:0] addrb_a, doutb_a, tdata_a;
    logic [3:0]  web_a;
    logic [1:0]  st_a;

    logic        start_b, busy_b, done_b, enb_b, tvalid_b, tready_b, tlast_b;
    logic [31:0] addrb_b, doutb_b, tdata_b;
    logic [3:0]  web_b;
    logic [1:0]  st_b;

    post_fft_bram_reader dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .busy(busy_a), .done(done_a),
        .addrb(addrb_a), .enb(enb_a), .web(web_a), .doutb(doutb_a),
        .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
        .m_axis_tlast(tlast_a), .dbg_state(st_a)
    );

    post_fft_bram_reader #(
        .NUM_WORDS(4), .BASE_ADDR(32'h40), .ADDR_STEP(32'd4), .READ_LATENCY(1)
    ) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .busy(busy_b), .done(done_b),
        .addrb(addrb_b), .enb(enb_b), .web(web_b), .doutb(doutb_b),
        .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
        .m_axis_tlast(tlast_b), .dbg_state(st_b)
    );

    // BRAM models: mem[i] = i + 0x100, latency 2 for A, latency 1 for B.
    logic [31:0] rd_a0, rd_a1, rd_b0;
    always @(posedge clk) begin
        if (enb_a) rd_a0 <= (addrb_a >> 2) + 32'h100;
        rd_a1 <= rd_a0;
        if (enb_b) rd_b0 <= ((addrb_b - 32'h40) >> 2) + 32'h100;
    end
    assign doutb_a = rd_a1;
    assign doutb_b = rd_b0;

    int checks = 0;
    int passed = 0;

    // 0: tready low, 1: tready high, 2: random 50%
    int ready_mode = 0;
    initial begin
        tready_a = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tready_a = 1'b0;
                1:       tready_a = 1'b1;
                default: tready_a = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Scoreboard for DUT A: {tlast, tdata} expected per beat.
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    int          issued_n = 0;
    int          accepted_n = 0;
    logic [31:0] last_addr = '0;
    bit          mon_en = 0;
    bit          prev_stall = 0;
    bit          prev_last_fire = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (enb_a) begin
                checks++;
                if (addrb_a !== (32'(issued_n % N) << 2))
                    $display("FAIL addrb: got %h expected %h", addrb_a, 32'(issued_n % N) << 2);
                else passed++;
                checks++;
                if ((issued_n - accepted_n) >= 4)
                    $display("FAIL occupancy: enb with %0d outstanding, limit 3", issued_n - accepted_n);
                else passed++;
                last_addr = addrb_a;
                issued_n++;
            end
            if (prev_stall) begin
                checks++;
                if ({tvalid_a, tlast_a, tdata_a} !== {1'b1, prev_last, prev_data})
                    $display("FAIL stall_hold: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                             tvalid_a, tlast_a, tdata_a, prev_last, prev_data);
                else passed++;
            end
            if (done_a || prev_last_fire) begin
                checks++;
                if (done_a !== prev_last_fire)
                    $display("FAIL done_timing: got %b expected %b", done_a, prev_last_fire);
                else passed++;
            end
            prev_last_fire = 0;
            if (tvalid_a && tready_a) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL beat: unexpected beat data %h", tdata_a);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({tlast_a, tdata_a} !== mon_e)
                        $display("FAIL beat: got last=%b data=%h expected last=%b data=%h",
                                 tlast_a, tdata_a, mon_e[32], mon_e[31:0]);
                    else passed++;
                end
                accepted_n++;
                prev_last_fire = tlast_a;
            end
            prev_stall = tvalid_a && !tready_a;
            prev_data  = tdata_a;
            prev_last  = tlast_a;
        end
    end

    task automatic push_frame();
        for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), 32'h100 + 32'(i)});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (done_a) ok = 1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        tready_b = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, done_a, enb_a, addrb_a, web_a, tvalid_a, tlast_a, tdata_a, st_a} !== '0)
            $display("FAIL reset_a: busy=%b done=%b enb=%b addrb=%h web=%h v=%b l=%b d=%h expected all 0",
                     busy_a, done_a, enb_a, addrb_a, web_a, tvalid_a, tlast_a, tdata_a);
        else passed++;
        checks++;
        if ({busy_b, done_b, enb_b, addrb_b, web_b, tvalid_b, tlast_b, tdata_b, st_b} !== '0)
            $display("FAIL reset_b: busy=%b enb=%b addrb=%h v=%b d=%h expected all 0",
                     busy_b, enb_b, addrb_b, tvalid_b, tdata_b);
        else passed++;
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_a, tvalid_a, enb_a} !== 3'b000)
            $display("FAIL idle_after_reset: busy=%b v=%b enb=%b expected 000", busy_a, tvalid_a, enb_a);
        else passed++;
    endtask

    task automatic test_stream();
        int first_v = -1;
        int done_cyc = -1;
        int bubbles = 0;
        int acc0;
        ready_mode = 1;
        acc0 = accepted_n;
        push_frame();
        mon_en = 1;
        pulse_start();
        for (int cyc = 1; cyc <= 3000 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                checks++;
                if ({busy_a, enb_a, addrb_a, web_a} !== {1'b1, 1'b1, 32'h0, 4'h0})
                    $display("FAIL first_issue: busy=%b enb=%b addrb=%h web=%h expected 1 1 0 0",
                             busy_a, enb_a, addrb_a, web_a);
                else passed++;
            end
            if (tvalid_a && first_v < 0) first_v = cyc;
            else if (first_v >= 0 && busy_a && !tvalid_a) bubbles++;
            if (done_a) done_cyc = cyc;
        end
        checks++;
        if (first_v !== 4) $display("FAIL first_tvalid: got cycle %0d expected 4", first_v);
        else passed++;
        checks++;
        if (bubbles !== 0) $display("FAIL no_bubbles: got %0d bubbles expected 0", bubbles);
        else passed++;
        checks++;
        if (done_cyc !== 4 + N) $display("FAIL done_cycle: got %0d expected %0d", done_cyc, 4 + N);
        else passed++;
        checks++;
        if (last_addr !== 32'd8188) $display("FAIL last_addr: got %0d expected 8188", last_addr);
        else passed++;
        checks++;
        if ((accepted_n - acc0) !== N || exp_q.size() !== 0)
            $display("FAIL beat_count: got %0d beats, %0d left expected %0d, 0",
                     accepted_n - acc0, exp_q.size(), N);
        else passed++;
        @(negedge clk);
        checks++;
        if ({done_a, busy_a} !== 2'b00) $display("FAIL done_pulse: done=%b busy=%b expected 0 0", done_a, busy_a);
        else passed++;
    endtask

    task automatic test_random_ready();
        bit ok;
        int acc0 = accepted_n;
        ready_mode = 2;
        push_frame();
        pulse_start();
        wait_done(20000, ok);
        checks++;
        if (!ok) $display("FAIL random_done: got timeout expected done");
        else passed++;
        checks++;
        if ((accepted_n - acc0) !== N || exp_q.size() !== 0)
            $display("FAIL random_count: got %0d beats, %0d left expected %0d, 0",
                     accepted_n - acc0, exp_q.size(), N);
        else passed++;
    endtask

    task automatic test_backpressure();
        bit got = 0;
        int bubbles = 0;
        int iss0;
        ready_mode = 0;
        push_frame();
        iss0 = issued_n;
        pulse_start();
        repeat (20) @(negedge clk);
        checks++;
        if ((issued_n - iss0) !== 4) $display("FAIL stall_reads: got %0d reads expected 4", issued_n - iss0);
        else passed++;
        checks++;
        if ({enb_a, tvalid_a, tdata_a, busy_a} !== {1'b0, 1'b1, 32'h100, 1'b1})
            $display("FAIL stall_state: enb=%b v=%b d=%h busy=%b expected 0 1 00000100 1",
                     enb_a, tvalid_a, tdata_a, busy_a);
        else passed++;
        ready_mode = 1;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (busy_a && tready_a && !tvalid_a) bubbles++;
            if (done_a) got = 1;
        end
        checks++;
        if (!got || bubbles !== 0)
            $display("FAIL resume: got done=%b bubbles=%0d expected done=1 bubbles=0", got, bubbles);
        else passed++;
        checks++;
        if (exp_q.size() !== 0) $display("FAIL resume_left: got %0d expected 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_back_to_back();
        int beats = 0;
        bit pulsed = 0;
        bit got = 0;
        bit ok;
        ready_mode = 1;
        push_frame();
        pulse_start();
        for (int c = 0; c < 5000 && !got; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (done_a) got = 1;
            else begin
                if (tvalid_a && tready_a) beats++;
                if (beats == 500 && !pulsed) begin
                    start_a = 1'b1;
                    pulsed = 1;
                end
            end
        end
        checks++;
        if (!got || exp_q.size() !== 0)
            $display("FAIL ignored_start: got done=%b left=%0d expected done=1 left=0", got, exp_q.size());
        else passed++;
        if (got) begin
            checks++;
            if (busy_a !== 1'b0) $display("FAIL busy_on_done: got %b expected 0", busy_a);
            else passed++;
            start_a = 1'b1;
            push_frame();
            @(posedge clk);
            #1 start_a = 1'b0;
            @(negedge clk);
            checks++;
            if (busy_a !== 1'b1) $display("FAIL restart_busy: got %b expected 1", busy_a);
            else passed++;
            wait_done(4000, ok);
            checks++;
            if (!ok || exp_q.size() !== 0)
                $display("FAIL second_frame: got done=%b left=%0d expected done=1 left=0", ok, exp_q.size());
            else passed++;
        end
    endtask

    task automatic test_reset_abort();
        int beats = 0;
        int viol = 0;
        bit ok;
        ready_mode = 1;
        push_frame();
        pulse_start();
        for (int c = 0; c < 3000 && beats < 1000; c++) begin
            @(negedge clk);
            if (tvalid_a && tready_a) beats++;
        end
        mon_en = 0;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, enb_a, addrb_a, web_a, tvalid_a, tlast_a, tdata_a, st_a} !== '0)
            $display("FAIL async_reset: busy=%b done=%b enb=%b addrb=%h v=%b l=%b d=%h expected all 0",
                     busy_a, done_a, enb_a, addrb_a, tvalid_a, tlast_a, tdata_a);
        else passed++;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        issued_n = 0;
        accepted_n = 0;
        prev_stall = 0;
        prev_last_fire = 0;
        repeat (10) begin
            @(negedge clk);
            if (tvalid_a || busy_a || done_a || enb_a) viol++;
        end
        checks++;
        if (viol !== 0) $display("FAIL post_reset_quiet: got %0d active cycles expected 0", viol);
        else passed++;
        push_frame();
        mon_en = 1;
        pulse_start();
        @(negedge clk);
        checks++;
        if ({enb_a, addrb_a} !== {1'b1, 32'h0}) $display("FAIL restart_addr: enb=%b addrb=%h expected 1 0", enb_a, addrb_a);
        else passed++;
        wait_done(3000, ok);
        checks++;
        if (!ok || exp_q.size() !== 0 || accepted_n !== N)
            $display("FAIL frame_after_reset: done=%b left=%0d beats=%0d expected 1 0 %0d",
                     ok, exp_q.size(), accepted_n, N);
        else passed++;
    endtask

    task automatic test_small_frame();
        logic [31:0] exp_addr[$];
        logic [32:0] exp_b[$];
        logic [31:0] ea;
        logic [32:0] eb;
        int dones = 0;
        int done_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'h40 + 32'(i * 4));
            exp_b.push_back({(i == 3), 32'h100 + 32'(i)});
        end
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (enb_b) begin
                checks++;
                if (exp_addr.size() == 0) $display("FAIL small_addr: extra read at %h", addrb_b);
                else begin
                    ea = exp_addr.pop_front();
                    if (addrb_b !== ea) $display("FAIL small_addr: got %h expected %h", addrb_b, ea);
                    else passed++;
                end
            end
            if (tvalid_b && tready_b) begin
                checks++;
                if (exp_b.size() == 0) $display("FAIL small_beat: extra beat %h", tdata_b);
                else begin
                    eb = exp_b.pop_front();
                    if ({tlast_b, tdata_b} !== eb)
                        $display("FAIL small_beat: got l=%b d=%h expected l=%b d=%h",
                                 tlast_b, tdata_b, eb[32], eb[31:0]);
                    else passed++;
                end
            end
            if (done_b) begin
                dones++;
                done_cyc = cyc;
            end
        end
        checks++;
        if (exp_addr.size() !== 0 || exp_b.size() !== 0)
            $display("FAIL small_left: got %0d addrs %0d beats left expected 0 0", exp_addr.size(), exp_b.size());
        else passed++;
        checks++;
        if (dones !== 1 || done_cyc !== 7)
            $display("FAIL small_done: got %0d pulses at cycle %0d expected 1 at 7", dones, done_cyc);
        else passed++;
        checks++;
        if ({st_b, busy_b} !== 3'b000) $display("FAIL small_idle: state=%0d busy=%b expected 0 0", st_b, busy_b);
        else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_random_ready();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        test_small_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
